// File: rtl/deser8_pkg.sv
// Shared constants and helpers for the _deser8 serial-to-parallel receiver.
// Optional feature macro used by the top: DESER8_ANYSET_EN.
package deser8_pkg;

    localparam int DESER8_WIDTH_DEF = 8;

    // Where a fresh bit enters the shift register: LSB-first shifts right and
    // enters at the top, MSB-first shifts left and enters at bit 0.
    localparam bit INS_AT_TOP    = 1'b1;
    localparam bit INS_AT_BOTTOM = 1'b0;

    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    function automatic bit ins_at_top(input bit lsb_first);
        return lsb_first ? INS_AT_TOP : INS_AT_BOTTOM;
    endfunction

endpackage

// File: rtl/_deser8_shreg.sv
// Shift register and bit counter for _deser8; exposes the word that would be
// completed by the bit currently offered, plus a flag for the final bit slot.
module _deser8_shreg
    import deser8_pkg::*;
#(
    parameter int WIDTH     = DESER8_WIDTH_DEF,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CW       = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             clr,
    input  logic             in_bit,
    output logic [WIDTH-1:0] next_word,
    output logic             last_bit,
    output logic [CW-1:0]    bit_count
);

    localparam bit AT_TOP = ins_at_top(LSB_FIRST);

    logic [WIDTH-1:0] sr;

    always_comb begin
        if (AT_TOP) next_word = {in_bit, sr[WIDTH-1:1]};
        else        next_word = {sr[WIDTH-2:0], in_bit};
        last_bit = (bit_count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr        <= '0;
            bit_count <= '0;
        end else if (clr) begin
            sr        <= '0;
            bit_count <= '0;
        end else if (shift) begin
            sr        <= next_word;
            bit_count <= last_bit ? '0 : bit_count + CW'(1);
        end
    end

endmodule

// File: rtl/_deser8.sv
// Serial-to-parallel receiver: assembles WIDTH accepted bits into a registered word.
// Build option DESER8_ANYSET_EN turns out_any into a registered OR of the word.
module _deser8
    import deser8_pkg::*;
#(
    parameter int WIDTH     = DESER8_WIDTH_DEF,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CW       = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_word,
    input  logic             out_ready,
    output logic [CW-1:0]    bit_count,
    output logic             out_any
);

    logic [WIDTH-1:0] next_word;
    logic             last_bit;
    logic             accept;
    logic             drain;
    logic             complete;

    // Only the final bit is gated by a full output stage, so earlier bits keep flowing.
    assign in_ready = ~clear & (~last_bit | ~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;
    assign complete = accept & last_bit;

    _deser8_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk       (clk),
        .reset     (reset),
        .shift     (accept),
        .clr       (clear),
        .in_bit    (in_bit),
        .next_word (next_word),
        .last_bit  (last_bit),
        .bit_count (bit_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_word  <= '0;
            out_valid <= 1'b0;
        end else if (complete) begin
            out_word  <= next_word;
            out_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DESER8_ANYSET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         out_any <= 1'b0;
        else if (complete) out_any <= |next_word;
    end
`else
    assign out_any = 1'b0;
`endif

endmodule

// File: tb/tb__deser8.sv
// Randomised and directed bench for _deser8: an LSB-first and an MSB-first
// instance share stimulus; completed words are checked through scoreboard queues.
module tb__deser8;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_l, out_valid_l, out_any_l;
    logic [7:0] out_word_l;
    logic [2:0] bit_count_l;
    logic       in_ready_m, out_valid_m, out_any_m;
    logic [7:0] out_word_m;
    logic [2:0] bit_count_m;

    int checks = 0;
    int errors = 0;

    bit         bits[$];
    logic [7:0] q_l[$];
    logic [7:0] q_m[$];
    bit         ov = 1'b0;
    bit         last_acc = 1'b0;

    always #5 clk = ~clk;

    _deser8 #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready_l), .out_valid(out_valid_l), .out_word(out_word_l),
        .out_ready(out_ready), .bit_count(bit_count_l), .out_any(out_any_l)
    );

    _deser8 #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready_m), .out_valid(out_valid_m), .out_word(out_word_m),
        .out_ready(out_ready), .bit_count(bit_count_m), .out_any(out_any_m)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_any(input logic [7:0] w);
`ifdef DESER8_ANYSET_EN
        return (w != 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: a list of accepted bits and a single output-pending flag.
    always @(negedge clk) begin
        bit m_ready, drain, acc, done;
        logic [7:0] wl, wm;
        if (reset) begin
            bits.delete();
            q_l.delete();
            q_m.delete();
            ov = 1'b0;
            last_acc = 1'b0;
        end else begin
            m_ready = !clear && (bits.size() != W - 1 || !ov || out_ready);
            check("in_ready_lsb", in_ready_l, m_ready);
            check("in_ready_msb", in_ready_m, m_ready);
            check("out_valid_lsb", out_valid_l, ov);
            check("out_valid_msb", out_valid_m, ov);
            check("bit_count_lsb", bit_count_l, bits.size());
            check("bit_count_msb", bit_count_m, bits.size());
            drain = ov && out_ready;
            acc = in_valid && m_ready;
            last_acc = acc;
            done = 1'b0;
            if (clear) begin
                bits.delete();
            end else if (acc) begin
                bits.push_back(in_bit);
                if (bits.size() == W) begin
                    wl = '0;
                    wm = '0;
                    for (int i = 0; i < W; i++) begin
                        wl = wl | (8'(bits[i]) << i);
                        wm = wm | (8'(bits[i]) << (W - 1 - i));
                    end
                    q_l.push_back(wl);
                    q_m.push_back(wm);
                    bits.delete();
                    done = 1'b1;
                end
            end
            if (done)       ov = 1'b1;
            else if (drain) ov = 1'b0;
        end
    end

    // Monitor: every drained word must match the oldest expected one.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset) begin
            if (out_valid_l && out_ready) begin
                if (q_l.size() == 0) check("unexpected_word_lsb", out_word_l, -1);
                else begin
                    e = q_l.pop_front();
                    check("out_word_lsb", out_word_l, e);
                    check("out_any_lsb", out_any_l, exp_any(e));
                end
            end
            if (out_valid_m && out_ready) begin
                if (q_m.size() == 0) check("unexpected_word_msb", out_word_m, -1);
                else begin
                    e = q_m.pop_front();
                    check("out_word_msb", out_word_m, e);
                    check("out_any_msb", out_any_m, exp_any(e));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        int n = 0;
        in_valid = 1'b1;
        in_bit = b;
        do begin
            step();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) check("send_timeout", 0, 1);
    endtask

    task automatic send_word_lsb(input logic [7:0] w);
        logic [7:0] t;
        t = w;
        for (int i = 0; i < W; i++) send_bit(t[i]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        logic [7:0] seq;
        #12;
        check("rst_out_valid", out_valid_l, 0);
        check("rst_out_word", out_word_l, 0);
        check("rst_bit_count", bit_count_m, 0);
        check("rst_out_any", out_any_l, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        step();

        // Bits 1,0,1,1,0,0,0,0: 0x0D LSB-first, 0xB0 MSB-first.
        out_ready = 1'b1;
        seq = 8'h0D;
        send_word_lsb(seq);
        idle(3);

        // Backpressure: second word's final bit must stall until out_ready rises.
        out_ready = 1'b0;
        send_word_lsb(8'hFF);
        seq = 8'h10;
        for (int i = 0; i < W - 1; i++) send_bit(seq[i]);
        in_valid = 1'b1;
        in_bit = seq[7];
        repeat (3) step();
        check("t4_stall_in_ready", in_ready_l, 0);
        check("t4_stall_out_word", out_word_l, 8'hFF);
        out_ready = 1'b1;
        send_bit(seq[7]);
        idle(3);

        // Clear discards a partial word and refuses the bit offered alongside it.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        in_valid = 1'b1;
        in_bit = 1'b1;
        clear = 1'b1;
        #3;
        check("t5_clear_in_ready", in_ready_l, 0);
        step();
        clear = 1'b0;
        check("t5_cleared_count", bit_count_l, 0);
        send_word_lsb(8'h01);
        idle(3);

        send_word_lsb(8'h00);
        send_word_lsb(8'h20);
        idle(3);

        // Asynchronous reset mid-word takes effect before the next edge.
        send_word_lsb(8'hA5);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t1_out_valid", out_valid_l, 0);
        check("t1_bit_count", bit_count_l, 0);
        check("t1_out_word", out_word_l, 0);
        check("t1_out_word_msb", out_word_m, 0);
        check("t1_out_any", out_any_l, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        step();

        for (int c = 0; c < 600; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bit = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            clear = ($urandom_range(0, 31) == 0);
            step();
        end
        clear = 1'b0;
        out_ready = 1'b1;
        idle(5);
        check("leftover_lsb", q_l.size(), 0);
        check("leftover_msb", q_m.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
